lsu_mem_port: RTL and testbench

- Load/store unit memory port. Sits between the scheduler/AGU, the RMW ALU and the single-ported data memory bus.
- Issues scheduled loads and stores, and issues the read half of RMW operations. It then accepts the RMW ALU's modified-data write-back and completes the write half.
- This block is the LSU end of the RMW write-back handshake (data, address, data-ready, hold, deny). It keeps one memory transaction outstanding at a time.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_mem_port_if.sv | 55 +++++
 rtl/lsu_mem_port.sv | 125 ++++++++++++
 tb/tb_lsu_mem_port.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory port: FSM state encoding, request kinds, RF tag width.
package lsu_pkg;

    localparam int TAG_W = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_RMW  = 3'd2,
        S_WAIT_WB = 3'd3,
        S_WR_RMW  = 3'd4,
        S_WR_ST   = 3'd5
    } lsu_state_t;

    typedef enum logic [2:0] {
        REQ_NONE   = 3'd0,
        REQ_LD     = 3'd1,
        REQ_ST     = 3'd2,
        REQ_RMW_RD = 3'd3,
        REQ_RMW_WR = 3'd4
    } req_kind_t;

endpackage

// File: rtl/lsu_mem_port_if.sv
// Scheduler, RMW ALU, register-file and memory-bus signals of the LSU memory port.
interface lsu_mem_port_if
    import lsu_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) ();

    logic             sched_ld;
    logic             sched_st;
    logic             sched_rmw;
    logic [TAG_W-1:0] sched_ld_tag;
    logic [AW-1:0]    agu_addr;
    logic [DW-1:0]    sched_st_data;
    logic             sched_stall;

    logic [DW-1:0]    rmw_data;
    logic [AW-1:0]    rmw_addr;
    logic             rmw_data_rdy;
    logic             rmw_deny_op;
    logic             rmw_hold;

    logic             rf_ld_wr;
    logic [TAG_W-1:0] rf_ld_tag;
    logic [DW-1:0]    rf_ld_data;

    logic             mem_req;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_data_out;
    logic             mem_rdy;
    logic [DW-1:0]    mem_data_in;

    // master is the LSU side
    modport master (
        input  sched_ld, sched_st, sched_rmw, sched_ld_tag, agu_addr, sched_st_data,
        output sched_stall,
        input  rmw_data, rmw_addr, rmw_data_rdy, rmw_deny_op,
        output rmw_hold,
        output rf_ld_wr, rf_ld_tag, rf_ld_data,
        output mem_req, mem_we, mem_addr, mem_data_out,
        input  mem_rdy, mem_data_in
    );

    modport slave (
        output sched_ld, sched_st, sched_rmw, sched_ld_tag, agu_addr, sched_st_data,
        input  sched_stall,
        output rmw_data, rmw_addr, rmw_data_rdy, rmw_deny_op,
        input  rmw_hold,
        input  rf_ld_wr, rf_ld_tag, rf_ld_data,
        input  mem_req, mem_we, mem_addr, mem_data_out,
        output mem_rdy, mem_data_in
    );

endinterface

// File: rtl/lsu_mem_port.sv
// LSU memory port: one bus transaction outstanding; mem_req one cycle after accept, done on mem_rdy.
// Backpressure: sched_stall whenever busy, an RMW write-back is pending, or the address is denied.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst,
    lsu_mem_port_if.master    bus
);

    lsu_state_t       state;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    data_q;
    logic [TAG_W-1:0] tag_q;
    logic             req_q;
    logic             we_q;

    logic             any_sched;
    logic             stall;
    logic             wb_done;
    logic             ld_done;
    req_kind_t        kind;

    always_comb begin
        any_sched = bus.sched_ld | bus.sched_st | bus.sched_rmw;
        stall     = any_sched & ((state != S_IDLE) | bus.rmw_data_rdy | bus.rmw_deny_op);
        wb_done   = (state == S_WR_RMW) & bus.mem_rdy;
        ld_done   = (state == S_RD) & bus.mem_rdy;
        kind      = REQ_NONE;
        // Pending write-back beats any new scheduler request
        if (state == S_IDLE) begin
            if (bus.rmw_data_rdy)   kind = REQ_RMW_WR;
            else if (!stall) begin
                if (bus.sched_rmw)     kind = REQ_RMW_RD;
                else if (bus.sched_st) kind = REQ_ST;
                else if (bus.sched_ld) kind = REQ_LD;
            end
        end
    end

    assign bus.sched_stall  = stall;
    assign bus.rmw_hold     = bus.rmw_data_rdy & ~wb_done;
    assign bus.rf_ld_wr     = ld_done;
    assign bus.rf_ld_tag    = ld_done ? tag_q : '0;
    assign bus.rf_ld_data   = ld_done ? bus.mem_data_in : '0;
    assign bus.mem_req      = req_q;
    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_data_out = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
            data_q <= '0;
            tag_q  <= '0;
            req_q  <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    case (kind)
                        REQ_RMW_WR: begin
                            state  <= S_WR_RMW;
                            addr_q <= bus.rmw_addr;
                            data_q <= bus.rmw_data;
                            req_q  <= 1'b1;
                            we_q   <= 1'b1;
                        end
                        REQ_RMW_RD: begin
                            state  <= S_RD_RMW;
                            addr_q <= bus.agu_addr;
                            req_q  <= 1'b1;
                            we_q   <= 1'b0;
                        end
                        REQ_ST: begin
                            state  <= S_WR_ST;
                            addr_q <= bus.agu_addr;
                            data_q <= bus.sched_st_data;
                            req_q  <= 1'b1;
                            we_q   <= 1'b1;
                        end
                        REQ_LD: begin
                            state  <= S_RD;
                            addr_q <= bus.agu_addr;
                            tag_q  <= bus.sched_ld_tag;
                            req_q  <= 1'b1;
                            we_q   <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_RD: if (bus.mem_rdy) begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
                // RMW ALU captures the read data straight off the bus
                S_RD_RMW: if (bus.mem_rdy) begin
                    state <= S_WAIT_WB;
                    req_q <= 1'b0;
                end
                S_WAIT_WB: if (bus.rmw_data_rdy) begin
                    state  <= S_WR_RMW;
                    addr_q <= bus.rmw_addr;
                    data_q <= bus.rmw_data;
                    req_q  <= 1'b1;
                    we_q   <= 1'b1;
                end
                S_WR_RMW, S_WR_ST: if (bus.mem_rdy) begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                    we_q  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    a_one_sched: assert property (@(posedge clk) disable iff (rst)
        $onehot0({bus.sched_ld, bus.sched_st, bus.sched_rmw}));

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: load, store, full RMW, deny, priority and mid-transaction reset.
module tb_lsu_mem_port;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    logic [15:0] mem_word;

    lsu_mem_port_if #(.AW(16), .DW(16)) bus ();

    lsu_mem_port #(.AW(16), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_req"},   32'(bus.mem_req), 32'd0);
        chk({tag, "_we"},    32'(bus.mem_we), 32'd0);
        chk({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
        chk({tag, "_dout"},  32'(bus.mem_data_out), 32'd0);
        chk({tag, "_rfwr"},  32'(bus.rf_ld_wr), 32'd0);
        chk({tag, "_hold"},  32'(bus.rmw_hold), 32'd0);
        chk({tag, "_stall"}, 32'(bus.sched_stall), 32'd0);
        chk({tag, "_state"}, 32'(dut.state), 32'd0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.sched_ld = 0; bus.sched_st = 0; bus.sched_rmw = 0;
        bus.sched_ld_tag = '0; bus.agu_addr = '0; bus.sched_st_data = '0;
        bus.rmw_data = '0; bus.rmw_addr = '0; bus.rmw_data_rdy = 0; bus.rmw_deny_op = 0;
        bus.mem_rdy = 0; bus.mem_data_in = '0;
        mem_word = '0;
        nxt(); nxt();
        rst = 1'b0;
        smp();
        chk_idle_outs("reset");

        // Load 0x1234 tag 5, data returned two cycles after issue
        nxt();
        bus.sched_ld = 1; bus.agu_addr = 16'h1234; bus.sched_ld_tag = 3'd5;
        smp();
        chk("ld_accept_stall", 32'(bus.sched_stall), 32'd0);
        chk("ld_accept_req", 32'(bus.mem_req), 32'd0);
        nxt();
        bus.sched_ld = 0;
        smp();
        chk("ld_req", 32'(bus.mem_req), 32'd1);
        chk("ld_we", 32'(bus.mem_we), 32'd0);
        chk("ld_addr", 32'(bus.mem_addr), 32'h1234);
        chk("ld_rfwr_early", 32'(bus.rf_ld_wr), 32'd0);
        nxt();
        bus.mem_rdy = 1; bus.mem_data_in = 16'hBEEF;
        smp();
        chk("ld_rfwr", 32'(bus.rf_ld_wr), 32'd1);
        chk("ld_data", 32'(bus.rf_ld_data), 32'hBEEF);
        chk("ld_tag", 32'(bus.rf_ld_tag), 32'd5);
        chk("ld_we_done", 32'(bus.mem_we), 32'd0);
        nxt();
        bus.mem_rdy = 0; bus.mem_data_in = '0;
        smp();
        chk("ld_rfwr_after", 32'(bus.rf_ld_wr), 32'd0);
        chk("ld_req_after", 32'(bus.mem_req), 32'd0);

        // Store 0xA5A5 to 0x0040, mem_rdy in first request cycle
        bus.sched_st = 1; bus.agu_addr = 16'h0040; bus.sched_st_data = 16'hA5A5;
        smp();
        chk("st_accept_stall", 32'(bus.sched_stall), 32'd0);
        nxt();
        bus.sched_st = 0; bus.mem_rdy = 1;
        smp();
        chk("st_req", 32'(bus.mem_req), 32'd1);
        chk("st_we", 32'(bus.mem_we), 32'd1);
        chk("st_addr", 32'(bus.mem_addr), 32'h0040);
        chk("st_dout", 32'(bus.mem_data_out), 32'hA5A5);
        chk("st_rfwr", 32'(bus.rf_ld_wr), 32'd0);
        nxt();
        bus.mem_rdy = 0;
        smp();
        chk("st_req_after", 32'(bus.mem_req), 32'd0);
        chk("st_we_after", 32'(bus.mem_we), 32'd0);

        // Full RMW at 0x0100: read 0x00FF, write back 0x0100
        bus.sched_rmw = 1; bus.agu_addr = 16'h0100;
        smp();
        chk("rmw_accept_stall", 32'(bus.sched_stall), 32'd0);
        nxt();
        bus.sched_rmw = 0; bus.mem_rdy = 1; bus.mem_data_in = 16'h00FF;
        smp();
        chk("rmw_rd_req", 32'(bus.mem_req), 32'd1);
        chk("rmw_rd_we", 32'(bus.mem_we), 32'd0);
        chk("rmw_rd_addr", 32'(bus.mem_addr), 32'h0100);
        chk("rmw_rd_rfwr", 32'(bus.rf_ld_wr), 32'd0);
        nxt();
        bus.mem_rdy = 0; bus.mem_data_in = '0;
        smp();
        chk("rmw_wait_req", 32'(bus.mem_req), 32'd0);
        chk("rmw_wait_hold", 32'(bus.rmw_hold), 32'd0);
        nxt();
        bus.rmw_data_rdy = 1; bus.rmw_data = 16'h0100; bus.rmw_addr = 16'h0100;
        smp();
        chk("rmw_wb_hold0", 32'(bus.rmw_hold), 32'd1);
        chk("rmw_wb_req0", 32'(bus.mem_req), 32'd0);
        nxt();
        smp();
        chk("rmw_wr_req", 32'(bus.mem_req), 32'd1);
        chk("rmw_wr_we", 32'(bus.mem_we), 32'd1);
        chk("rmw_wr_addr", 32'(bus.mem_addr), 32'h0100);
        chk("rmw_wr_dout", 32'(bus.mem_data_out), 32'h0100);
        chk("rmw_wr_hold", 32'(bus.rmw_hold), 32'd1);
        nxt();
        bus.mem_rdy = 1;
        smp();
        chk("rmw_done_hold", 32'(bus.rmw_hold), 32'd0);
        chk("rmw_done_req", 32'(bus.mem_req), 32'd1);
        nxt();
        bus.mem_rdy = 0; bus.rmw_data_rdy = 0;
        smp();
        chk("rmw_after_req", 32'(bus.mem_req), 32'd0);
        chk("rmw_after_we", 32'(bus.mem_we), 32'd0);

        // Deny: load to 0x0100 held off until the RMW write-back lands
        bus.sched_rmw = 1; bus.agu_addr = 16'h0100;
        nxt();
        bus.sched_rmw = 0; bus.mem_rdy = 1; bus.mem_data_in = 16'h0100;
        nxt();
        bus.mem_rdy = 0; bus.mem_data_in = '0;
        bus.sched_ld = 1; bus.sched_ld_tag = 3'd2; bus.rmw_deny_op = 1;
        smp();
        chk("deny_stall0", 32'(bus.sched_stall), 32'd1);
        chk("deny_req0", 32'(bus.mem_req), 32'd0);
        nxt();
        smp();
        chk("deny_stall1", 32'(bus.sched_stall), 32'd1);
        chk("deny_req1", 32'(bus.mem_req), 32'd0);
        nxt();
        bus.rmw_data_rdy = 1; bus.rmw_data = 16'h0101; bus.rmw_addr = 16'h0100;
        smp();
        chk("deny_stall2", 32'(bus.sched_stall), 32'd1);
        nxt();
        bus.mem_rdy = 1;
        smp();
        chk("deny_wr_stall", 32'(bus.sched_stall), 32'd1);
        chk("deny_wr_we", 32'(bus.mem_we), 32'd1);
        chk("deny_wr_addr", 32'(bus.mem_addr), 32'h0100);
        chk("deny_wr_hold", 32'(bus.rmw_hold), 32'd0);
        mem_word = bus.mem_data_out;
        nxt();
        bus.mem_rdy = 0; bus.rmw_data_rdy = 0; bus.rmw_deny_op = 0;
        smp();
        chk("deny_rel_stall", 32'(bus.sched_stall), 32'd0);
        chk("deny_rel_req", 32'(bus.mem_req), 32'd0);
        nxt();
        bus.sched_ld = 0; bus.mem_rdy = 1; bus.mem_data_in = mem_word;
        smp();
        chk("deny_ld_we", 32'(bus.mem_we), 32'd0);
        chk("deny_ld_addr", 32'(bus.mem_addr), 32'h0100);
        chk("deny_ld_rfwr", 32'(bus.rf_ld_wr), 32'd1);
        chk("deny_ld_data", 32'(bus.rf_ld_data), 32'h0101);
        chk("deny_ld_tag", 32'(bus.rf_ld_tag), 32'd2);
        nxt();
        bus.mem_rdy = 0; bus.mem_data_in = '0;

        // Priority: write-back and store in the same idle cycle
        bus.rmw_data_rdy = 1; bus.rmw_addr = 16'h0200; bus.rmw_data = 16'h1111;
        bus.sched_st = 1; bus.agu_addr = 16'h0300; bus.sched_st_data = 16'h2222;
        smp();
        chk("pri_stall", 32'(bus.sched_stall), 32'd1);
        chk("pri_hold", 32'(bus.rmw_hold), 32'd1);
        nxt();
        bus.mem_rdy = 1;
        smp();
        chk("pri_wb_addr", 32'(bus.mem_addr), 32'h0200);
        chk("pri_wb_dout", 32'(bus.mem_data_out), 32'h1111);
        chk("pri_wb_we", 32'(bus.mem_we), 32'd1);
        chk("pri_wb_stall", 32'(bus.sched_stall), 32'd1);
        chk("pri_wb_hold", 32'(bus.rmw_hold), 32'd0);
        nxt();
        bus.mem_rdy = 0; bus.rmw_data_rdy = 0;
        smp();
        chk("pri_st_accept", 32'(bus.sched_stall), 32'd0);
        nxt();
        bus.sched_st = 0; bus.mem_rdy = 1;
        smp();
        chk("pri_st_req", 32'(bus.mem_req), 32'd1);
        chk("pri_st_addr", 32'(bus.mem_addr), 32'h0300);
        chk("pri_st_dout", 32'(bus.mem_data_out), 32'h2222);
        nxt();
        bus.mem_rdy = 0;
        smp();
        chk("pri_st_after", 32'(bus.mem_req), 32'd0);

        // Reset while a load is outstanding
        bus.sched_ld = 1; bus.agu_addr = 16'h0555; bus.sched_ld_tag = 3'd7;
        nxt();
        bus.sched_ld = 0;
        smp();
        chk("rst_rd_req", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        smp();
        chk_idle_outs("midrst");
        nxt();
        bus.mem_rdy = 1; bus.mem_data_in = 16'h7777;
        smp();
        chk("midrst_rfwr", 32'(bus.rf_ld_wr), 32'd0);
        chk("midrst_req", 32'(bus.mem_req), 32'd0);
        nxt();
        bus.mem_rdy = 0; bus.mem_data_in = '0;
        smp();
        chk("midrst_state", 32'(dut.state), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
